// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the lane extract/merge helpers used by the alignment datapath.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Pull the addressed little-endian lane out of a word and extend it.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size,
        input logic        is_unsigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addr_lo, 3'b000} +: 8];
        h = word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{b[7] & ~is_unsigned}}, b};
            SZ_HALF: r = {{16{h[15] & ~is_unsigned}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with the low store data.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  addr_lo,
        input logic [1:0]  size
    );
        logic [31:0] r;
        r = old_word;
        case (size)
            SZ_BYTE: r[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: r[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane datapath: extended load data from the memory read word,
// and the merged store word built from the captured old word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    assign o_load_data  = lane_extract(i_rd_word, i_addr_lo, i_size, i_unsigned);
    assign o_merge_data = lane_merge(i_old_word, i_wdata, i_addr_lo, i_size);

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front-end for a word-addressed data memory.
// One request in flight; sub-word stores are done as read-modify-write.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request; checks it and latches it on accept
// RD      | memory read strobe; load lane captured or old word saved
// WR      | memory write strobe with the merged (or full) word
// RESP    | response held until the consumer takes it
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWe,
    input  logic [1:0]  ReqSize,
    input  logic        ReqUnsigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspRData,
    output logic        RspErr,
    output logic [31:0] MemAddress,
    output logic [31:0] MemDataIn,
    output logic        MemW,
    output logic        MemR,
    input  logic [31:0] MemDataOut
);

    lsu_state_e  r_state;
    lsu_state_e  w_next_state;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_old;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    // Errors are judged on the raw request so a bad access never reaches RD/WR.
    assign w_req_err = (ReqSize == 2'b11)
                    || ((ReqSize == SZ_HALF) && ReqAddr[0])
                    || ((ReqSize == SZ_WORD) && (ReqAddr[1:0] != 2'b00))
                    || ({2'b00, ReqAddr[31:2]} >= DEPTH);

    assign w_accept = ReqValid && ReqReady;

    lsu_lane_align u_align (
        .i_rd_word    (MemDataOut),
        .i_old_word   (r_old),
        .i_wdata      (r_wdata),
        .i_addr_lo    (r_addr[1:0]),
        .i_size       (r_size),
        .i_unsigned   (r_uns),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Memory side comes only from registers so it is steady for a level write.
    assign MemAddress = {2'b00, r_addr[31:2]};
    assign MemDataIn  = (r_state == ST_WR) ? w_merge_data : 32'h0;
    assign RspRData   = r_rdata;
    assign RspErr     = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_next_state = r_state;
        ReqReady     = 1'b0;
        RspValid     = 1'b0;
        MemR         = 1'b0;
        MemW         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) begin
                    if (w_req_err) begin
                        w_next_state = ST_RESP;
                    end else if (!ReqWe || (ReqSize != SZ_WORD)) begin
                        w_next_state = ST_RD;
                    end else begin
                        w_next_state = ST_WR;
                    end
                end
            end
            ST_RD: begin
                MemR         = 1'b1;
                w_next_state = r_we ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                MemW         = 1'b1;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                RspValid = 1'b1;
                if (RspReady) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request capture on accept; read data or old word captured in RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_old   <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= ReqWe;
                        r_size  <= ReqSize;
                        r_uns   <= ReqUnsigned;
                        r_addr  <= ReqAddr;
                        r_wdata <= ReqWData;
                        r_err   <= w_req_err;
                        r_rdata <= 32'h0;
                    end
                end
                ST_RD: begin
                    if (r_we) begin
                        r_old <= MemDataOut;
                    end else begin
                        r_rdata <= w_load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
